ebus_dma_master: RTL
====================

EBUS_DMA_MASTER -- requirements
Module: ebus_dma_master

Interface
REQ-001 Parameter ACK_TIMEOUT, default 4095, clk cycles to wait for busack before flagging an error.
REQ-002 clk  in  1  system clock (sysclk domain); all logic SHALL be clocked on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 phi_re  in  1  one-clk strobe marking each rising edge of the generated Z80 phi.
REQ-005 acquire / release  in  1 each  one-clk requests from the ESP SPI command decoder.
REQ-006 cmd_valid, cmd_wr, cmd_addr[15:0], cmd_wrdata[7:0]  in  memory-cycle request; cmd_ready  out  1  accept strobe.
REQ-007 rd_data[7:0], rd_valid  out  read result and one-clk valid.
REQ-008 owned  out  1  bus held; error  out  1  sticky fault flag, cleared by the next acquire.
REQ-009 ebus_busreq_n  out  1; ebus_busack_n  in  1 (asynchronous input).
REQ-010 ebus_a_out[15:0], ebus_d_out[7:0], ebus_rd_n_out, ebus_wr_n_out, ebus_mreq_n_out  out  bus drive values.
REQ-011 ebus_ctl_oe (a, rd_n, wr_n, mreq_n), ebus_d_oe  out  1 each; ebus_d_in[7:0]  in  data bus sample.

Function
REQ-012 ebus_busack_n SHALL pass through a 2-flop synchronizer (ack_s) before use; reset value 1.
REQ-013 States SHALL be IDLE, REQ, OWN, T1, T2, T3, HOLD.
REQ-014 IDLE: busreq_n=1, both oe=0, cmd_ready=0; acquire -> REQ, error cleared, timeout counter zeroed.
REQ-015 REQ: busreq_n=0; ack_s==0 -> OWN; counter reaching ACK_TIMEOUT -> IDLE with error=1; release -> IDLE, error unchanged.
REQ-016 OWN: owned=1, ebus_ctl_oe=1, rd_n=wr_n=mreq_n=1; cmd_ready=cmd_valid (one-clk); on accept latch addr/data/dir -> T1.
REQ-017 release in OWN with no cmd_valid -> IDLE in the next clk; cmd_valid and release in the same clk: command SHALL win, release ignored.
REQ-018 T1: next phi_re drives ebus_a_out=latched addr -> T2.
REQ-019 T2: next phi_re asserts mreq_n=0 and rd_n=0 (read) or wr_n=0 with ebus_d_oe=1 (write) -> T3.
REQ-020 T3: next phi_re (the T3-closing edge) deasserts mreq_n/rd_n/wr_n; read SHALL capture ebus_d_in into rd_data and pulse rd_valid in the same clk -> HOLD.
REQ-021 HOLD: address and ebus_d_out held one further clk, ebus_d_oe dropped at HOLD exit -> OWN.
REQ-022 Cycle latency accept-to-rd_valid SHALL be exactly 3 phi_re strobes; no second command accepted before HOLD completes.
REQ-023 ack_s returning to 1 in any of OWN..HOLD SHALL drop all oe and busreq_n in the next clk, set error=1, abort any cycle without rd_valid, -> IDLE.
REQ-024 acquire while not IDLE and release while in T1..HOLD SHALL be ignored.
REQ-025 ebus_a_out SHALL keep last driven value when not owned; ebus_d_out SHALL equal latched cmd_wrdata.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, busreq_n=1, ebus_ctl_oe=0, ebus_d_oe=0, rd_n=wr_n=mreq_n=1, cmd_ready=0, rd_valid=0, owned=0, error=0, rd_data=0, ebus_a_out=0, ebus_d_out=0, ack_s=1, independent of clk.
REQ-027 Reset asserted mid bus cycle SHALL release the bus within zero clk cycles; no partial write strobe shall persist after reset_n rises.

Verification
REQ-028 acquire, model busack_n=busreq_n sampled on phi -> busreq_n 0, owned=1 within 2 phi periods plus 2 clk, error=0.
REQ-029 write 0x5A to 0x3000 -> address 0x3000 after 1st phi_re, mreq_n=wr_n=0 with d=0x5A after 2nd, strobes high after 3rd, d_oe low one clk later.
REQ-030 read 0x3400 with bus model returning 0xA5 -> rd_valid on 3rd phi_re, rd_data=0xA5, no d_oe assertion.
REQ-031 acquire with busack_n tied 1 -> error=1 and IDLE after ACK_TIMEOUT clks, busreq_n back to 1; next acquire clears error.
REQ-032 cmd_valid and release same clk in OWN -> command executes, bus remains owned; later release -> busreq_n=1, oe=0 next clk.
REQ-033 reset_n pulsed low during T2 of a write -> wr_n, mreq_n, oe, busreq_n released asynchronously; after reset, state IDLE, no rd_valid.

Source files
------------

// File: rtl/ebus_dma_master.sv
// Z80 expansion-bus DMA master: requests the bus with BUSREQ, then runs single
// memory read/write cycles paced by the phi rising-edge strobe.
module ebus_dma_master #(
    parameter int ACK_TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        phi_re,
    input  logic        acquire,
    input  logic        release_req,
    input  logic        cmd_valid,
    input  logic        cmd_wr,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wrdata,
    output logic        cmd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        owned,
    output logic        error,
    output logic        ebus_busreq_n,
    input  logic        ebus_busack_n,
    output logic [15:0] ebus_a_out,
    output logic [7:0]  ebus_d_out,
    output logic        ebus_rd_n_out,
    output logic        ebus_wr_n_out,
    output logic        ebus_mreq_n_out,
    output logic        ebus_ctl_oe,
    output logic        ebus_d_oe,
    input  logic [7:0]  ebus_d_in
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_OWN, S_T1, S_T2, S_T3, S_HOLD
    } state_t;

    state_t           state, state_nxt;
    logic             ack_meta, ack_s;
    logic [CNT_W-1:0] tmo_cnt;
    logic             lat_wr;
    logic [15:0]      lat_addr;
    logic             bus_held, ack_lost, tmo_hit, accept;

    // busack_n arrives from the Z80 side with no timing relation to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta <= 1'b1;
            ack_s    <= 1'b1;
        end else begin
            ack_meta <= ebus_busack_n;
            ack_s    <= ack_meta;
        end
    end

    always_comb begin
        bus_held = state inside {S_OWN, S_T1, S_T2, S_T3, S_HOLD};
        ack_lost = bus_held && ack_s;
        tmo_hit  = (state == S_REQ) && ack_s && (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));
        accept   = (state == S_OWN) && cmd_valid && !ack_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Losing busack always wins; a pending command beats a release in OWN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (acquire) state_nxt = S_REQ;
            S_REQ: begin
                if (!ack_s)           state_nxt = S_OWN;
                else if (tmo_hit)     state_nxt = S_IDLE;
                else if (release_req) state_nxt = S_IDLE;
            end
            S_OWN: begin
                if (ack_s)            state_nxt = S_IDLE;
                else if (cmd_valid)   state_nxt = S_T1;
                else if (release_req) state_nxt = S_IDLE;
            end
            S_T1:   if (ack_s) state_nxt = S_IDLE; else if (phi_re) state_nxt = S_T2;
            S_T2:   if (ack_s) state_nxt = S_IDLE; else if (phi_re) state_nxt = S_T3;
            S_T3:   if (ack_s) state_nxt = S_IDLE; else if (phi_re) state_nxt = S_HOLD;
            S_HOLD: state_nxt = ack_s ? S_IDLE : S_OWN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt    <= '0;
            error      <= 1'b0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            ebus_d_out <= '0;
            ebus_a_out <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == S_IDLE && acquire) begin
                error   <= 1'b0;
                tmo_cnt <= '0;
            end else if (state == S_REQ) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit || ack_lost)
                error <= 1'b1;
            if (accept) begin
                lat_wr     <= cmd_wr;
                lat_addr   <= cmd_addr;
                ebus_d_out <= cmd_wrdata;
            end
            if (state == S_T1 && phi_re && !ack_s)
                ebus_a_out <= lat_addr;
            // read data is sampled on the same edge that closes T3
            if (state == S_T3 && phi_re && !ack_s && !lat_wr) begin
                rd_data  <= ebus_d_in;
                rd_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        ebus_busreq_n   = (state == S_IDLE);
        owned           = bus_held;
        ebus_ctl_oe     = bus_held;
        cmd_ready       = accept;
        ebus_mreq_n_out = !(state == S_T3);
        ebus_rd_n_out   = !(state == S_T3 && !lat_wr);
        ebus_wr_n_out   = !(state == S_T3 && lat_wr);
        ebus_d_oe       = (state == S_T3 || state == S_HOLD) && lat_wr;
    end

endmodule
